// File: rtl/serial_paralelo_param_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_paralelo_param_if
//  Description : Serial-in / word-out bundle for the comma-aligned
//                deserialiser. The master side drives the serial bit and the
//                realign request; the slave side returns the deserialised
//                word with its qualifiers.
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_paralelo_param_if #(
  parameter int WIDTH = 8
);

  logic             data_in;
  logic             realign;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             word_strobe;
  logic             locked;

  modport master (
    output data_in,
    output realign,
    input  data_out,
    input  valid_out,
    input  word_strobe,
    input  locked
  );

  modport slave (
    input  data_in,
    input  realign,
    output data_out,
    output valid_out,
    output word_strobe,
    output locked
  );

endinterface
`default_nettype wire

// File: rtl/serial_paralelo_param.sv
`default_nettype none
// ============================================================================
//  Module      : serial_paralelo_param
//  Description : Parameterised serial-to-parallel converter with COMMA-based
//                word alignment. A bit-sliding HUNT finds the first COMMA,
//                ALIGN confirms LOCK_COUNT word-aligned COMMAs, and LOCKED
//                emits one word per WIDTH bit clocks (MSB first).
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_paralelo_param #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA      = WIDTH'(8'hBC),
  parameter int               LOCK_COUNT = 4
) (
  input  wire logic               clk_32f,
  input  wire logic               reset,
  serial_paralelo_param_if.slave  bus
);

  localparam int c_bit_w   = $clog2(WIDTH);
  localparam int c_comma_w = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);

  localparam logic [c_bit_w-1:0]   c_last_bit = c_bit_w'(WIDTH - 1);
  localparam logic [c_comma_w-1:0] c_lock_cnt = c_comma_w'(LOCK_COUNT);
  localparam logic [c_comma_w-1:0] c_one      = c_comma_w'(1);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t               r_state;
  // Only the low WIDTH-1 bits of the shift register are ever reused, since
  // the candidate word is always {sr[WIDTH-2:0], data_in}.
  logic [WIDTH-2:0]     r_sr;
  logic [c_bit_w-1:0]   r_bit_cnt;
  logic [c_comma_w-1:0] r_comma_cnt;
  logic [WIDTH-1:0]     r_data_out;
  logic                 r_valid_out;
  logic                 r_word_strobe;
  logic                 r_locked;

  logic [WIDTH-1:0]     w_word;
  logic                 w_is_comma;
  logic                 w_word_done;
  logic [c_comma_w-1:0] w_comma_next;

  // Candidate word seen on this edge, word-boundary flag and saturating
  // COMMA count used by ALIGN.
  always_comb begin
    w_word       = {r_sr, bus.data_in};
    w_is_comma   = (w_word == COMMA);
    w_word_done  = (r_bit_cnt == c_last_bit);
    w_comma_next = (r_comma_cnt >= c_lock_cnt) ? c_lock_cnt
                                               : (r_comma_cnt + c_one);
  end

  // Alignment FSM with shift register, counters and registered outputs.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      r_state       <= ST_HUNT;
      r_sr          <= '0;
      r_bit_cnt     <= '0;
      r_comma_cnt   <= '0;
      r_data_out    <= '0;
      r_valid_out   <= 1'b0;
      r_word_strobe <= 1'b0;
      r_locked      <= 1'b0;
    end else begin
      // The shifter never stalls, so a realign resumes hunting immediately.
      r_sr          <= w_word[WIDTH-2:0];
      r_word_strobe <= 1'b0;

      if (bus.realign) begin
        // Realign has priority over any completion or COMMA on this edge.
        r_state     <= ST_HUNT;
        r_comma_cnt <= '0;
        r_data_out  <= '0;
        r_valid_out <= 1'b0;
        r_locked    <= 1'b0;
      end else begin
        case (r_state)
          ST_HUNT: begin
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            if (w_is_comma) begin
              // This COMMA defines the word boundary: next edge is bit 0.
              r_bit_cnt   <= '0;
              r_comma_cnt <= c_one;
              if (LOCK_COUNT <= 1) begin
                r_state  <= ST_LOCKED;
                r_locked <= 1'b1;
              end else begin
                r_state <= ST_ALIGN;
              end
            end
          end

          ST_ALIGN: begin
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            if (w_word_done) begin
              r_bit_cnt <= '0;
              if (w_is_comma) begin
                r_comma_cnt <= w_comma_next;
                if (w_comma_next == c_lock_cnt) begin
                  // The final locking COMMA is absorbed without a strobe.
                  r_state  <= ST_LOCKED;
                  r_locked <= 1'b1;
                end
              end else begin
                r_state     <= ST_HUNT;
                r_comma_cnt <= '0;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end

          ST_LOCKED: begin
            if (w_word_done) begin
              r_bit_cnt     <= '0;
              r_data_out    <= w_word;
              r_valid_out   <= ~w_is_comma;
              r_word_strobe <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end

          default: begin
            r_state     <= ST_HUNT;
            r_comma_cnt <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_locked    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.data_out    = r_data_out;
  assign bus.valid_out   = r_valid_out;
  assign bus.word_strobe = r_word_strobe;
  assign bus.locked      = r_locked;

endmodule
`default_nettype wire

// File: doc/serial_paralelo_param.md
SERIAL_PARALELO_PARAM -- requirements
Module: serial_paralelo_param

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter WIDTH, default 8: deserialised word width in bits; legal range 4..32.
REQ-003 Parameter COMMA, default 8'hBC (WIDTH bits): alignment/idle symbol.
REQ-004 Parameter LOCK_COUNT, default 4: consecutive word-aligned COMMAs required for lock; legal minimum 1.
REQ-005 clk_32f  input  1  bit clock, rising-edge active; one serial bit per edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 data_in  input  1  serial data, MSB first.
REQ-008 realign  input  1  synchronous request to drop lock and re-hunt.
REQ-009 data_out  output  WIDTH  last deserialised word while locked.
REQ-010 valid_out  output  1  data_out holds a non-COMMA word.
REQ-011 word_strobe  output  1  one-cycle pulse per completed word while locked.
REQ-012 locked  output  1  high while the FSM is in LOCKED.

Function
REQ-013 Every edge SHALL form w = {sr[WIDTH-2:0], data_in} and then load sr <= w.
REQ-014 The FSM SHALL use three states: HUNT, ALIGN and LOCKED.
REQ-015 bit_cnt SHALL count 0..WIDTH-1 and wrap to 0; a word completes on the edge where bit_cnt == WIDTH-1.
REQ-016 In HUNT, on any edge where w == COMMA (bit-sliding search), the FSM SHALL set bit_cnt <= 0 and comma_cnt <= 1, then:
- go to LOCKED if LOCK_COUNT == 1;
- otherwise go to ALIGN.
REQ-017 In ALIGN, at word completion:
- if w == COMMA, increment comma_cnt and go to LOCKED when the new count equals LOCK_COUNT;
- if w != COMMA, return to HUNT with comma_cnt <= 0.
REQ-018 The locking COMMA words SHALL NOT produce word_strobe.
REQ-019 In LOCKED, at each word completion, the block SHALL load data_out <= w, valid_out <= (w != COMMA) and word_strobe <= 1, all registered on that same edge.
- Latency: 1 edge after the last bit is presented.
REQ-020 In LOCKED, data_out and valid_out SHALL hold between completions, and word_strobe SHALL be 0 on non-completion edges.
REQ-021 In LOCKED, COMMA words SHALL be reported with valid_out = 0 and word_strobe = 1; lock SHALL be kept.
REQ-022 In HUNT and ALIGN, the block SHALL hold data_out at 0, valid_out at 0 and word_strobe at 0.
REQ-023 When realign == 1 in any state, the next state SHALL be HUNT with comma_cnt <= 0, valid_out <= 0, word_strobe <= 0 and data_out <= 0; realign SHALL win over a same-edge word completion or COMMA match.
REQ-024 sr SHALL keep shifting during realign so that the HUNT search resumes on the next edge.
REQ-025 bit_cnt SHALL be don't-care in HUNT and SHALL be forced to 0 on every HUNT exit.
REQ-026 comma_cnt SHALL be ceil(log2(LOCK_COUNT+1)) bits wide and SHALL saturate at LOCK_COUNT.
REQ-027 The locked output SHALL be registered, equal to (state == LOCKED), and SHALL change on the same edge as the state change.

Reset
REQ-028 While reset is high, the block SHALL asynchronously clear state to HUNT and clear sr, bit_cnt, comma_cnt, data_out, valid_out, word_strobe and locked to 0.
REQ-029 Reset asserted mid-word or mid-lock SHALL abandon the partial word with no strobe, and lock SHALL be re-acquired from HUNT.
REQ-030 The first edge after reset deassertion SHALL shift a bit and SHALL be subject to the normal HUNT rules.

Verification
REQ-031 A bench SHALL cover the following directed scenarios, with WIDTH=8, COMMA=BC, LOCK_COUNT=4:
- Clean lock: 3 random bits, then 4x BC, then 8'h5A, 8'hBC, 8'hC3 -> locked rises on the last bit of the 4th BC; data_out = 5A/valid 1, then BC/valid 0, then C3/valid 1, each with a 1-cycle word_strobe every 8 clocks; no strobe during the lock BCs.
- Misaligned false comma: stream containing BC split across a word boundary, then 2x BC, then 8'h00 -> FSM returns HUNT; locked stays 0; no strobe.
- Broken lock sequence: 2x BC, then 8'h11, then 4x BC -> ALIGN drops to HUNT on 11; locked rises only after the last 4 BCs.
- Realign coincident with word completion while locked (word 8'hAA) -> no strobe for AA; locked=0 and data_out=0 next edge; relock after 4 BC.
- Reset asserted asynchronously mid-word while locked -> all outputs 0 immediately without a clock edge; after release, 4x BC relocks.
- WIDTH=10, COMMA=10'h17C, LOCK_COUNT=1 -> a single 17C locks; the next word 10'h2A5 is strobed with valid_out=1.
